front_line_writer: RTL and testbench

FRONT_LINE_WRITER -- requirements
Module: front_line_writer

---
 rtl/front_pkg.sv | 23 ++
 rtl/front_pix_shifter.sv | 33 +++
 rtl/front_line_writer.sv | 123 ++++++++++++
 tb/tb_front_line_writer.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/front_pkg.sv
// Shared types and constants for the sprite front-end line writer.
package front_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ATTR,
    CHECK,
    FETCH0,
    FETCH1,
    LOAD,
    PIX,
    DONE
  } state_t;

  localparam int Y_LSB    = 0;
  localparam int X_LSB    = 9;
  localparam int TILE_LSB = 18;
  localparam int PAL_LSB  = 27;

  localparam int SPR_H = 16;
  localparam logic [2:0] TRANSPARENT = 3'b111;

endpackage

// File: rtl/front_pix_shifter.sv
// Serializes two fetched 24-bit graphics words into 16 3-bit pixels.
module front_pix_shifter
  import front_pkg::*;
(
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [47:0] i_data,
  input  logic        i_shift,
  output logic [2:0]  o_color,
  output logic        o_last
);

  logic [47:0] r_sr;
  logic [3:0]  r_cnt;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_sr  <= i_data;
      r_cnt <= '0;
    end else if (i_shift) begin
      r_sr  <= {3'b000, r_sr[47:3]};
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign o_color = r_sr[2:0];
  assign o_last  = (r_cnt == 4'(SPR_H - 1));

endmodule

// File: rtl/front_line_writer.sv
// Scans sprite attributes for one line, fetches hit rows and
// streams their pixels into the line buffer.
module front_line_writer
  import front_pkg::*;
#(
  parameter int NSPR = 64
) (
  input  logic                    clk,
  input  logic                    VIDEO_RST,
  input  logic                    CK0,
  input  logic                    HLD,
  input  logic [8:0]              FY,
  output logic [$clog2(NSPR)-1:0] attr_addr,
  input  logic [31:0]             attr_data,
  output logic                    gfx_req,
  output logic [13:0]             gfx_addr,
  input  logic                    gfx_ack,
  input  logic [23:0]             gfx_data,
  output logic [7:0]              FD,
  output logic                    LD,
  output logic [8:0]              FL_Y,
  output logic                    busy
);

  localparam int IW = $clog2(NSPR);

  state_t          r_state, w_next;
  logic [8:0]      r_fy, r_x, r_tile;
  logic [IW-1:0]   r_idx;
  logic [4:0]      r_pal;
  logic [3:0]      r_row;
  logic [23:0]     r_w0, r_w1;

  logic [8:0]      w_y, w_row;
  logic            w_hit, w_eol, w_last_idx;
  logic            w_pix_last, w_advance;
  logic [2:0]      w_color;

  assign w_y        = attr_data[Y_LSB +: 9];
  assign w_row      = r_fy - w_y;
  assign w_hit      = (w_row < 9'(SPR_H));
  assign w_eol      = (w_y == 9'h1FF);
  assign w_last_idx = (r_idx == IW'(NSPR - 1));

  assign w_advance =
    ((r_state == CHECK) && !w_eol && !w_hit) ||
    ((r_state == PIX) && CK0 && w_pix_last);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:   w_next = IDLE;
      ATTR:   w_next = CHECK;
      CHECK: begin
        if (w_eol)           w_next = DONE;
        else if (w_hit)      w_next = FETCH0;
        else if (w_last_idx) w_next = DONE;
        else                 w_next = ATTR;
      end
      FETCH0: if (gfx_ack) w_next = FETCH1;
      FETCH1: if (gfx_ack) w_next = LOAD;
      LOAD:   if (CK0) w_next = PIX;
      PIX: begin
        if (CK0 && w_pix_last)
          w_next = w_last_idx ? DONE : ATTR;
      end
      DONE:   w_next = DONE;
      default: w_next = IDLE;
    endcase
    // A new line start aborts whatever is in flight.
    if (HLD) w_next = ATTR;
  end

  always_ff @(posedge clk) begin
    if (VIDEO_RST) begin
      r_state <= IDLE;
      r_fy    <= '0;
      r_idx   <= '0;
      r_x     <= '0;
      r_tile  <= '0;
      r_pal   <= '0;
      r_row   <= '0;
      r_w0    <= '0;
      r_w1    <= '0;
    end else begin
      r_state <= w_next;
      if (HLD) begin
        r_fy  <= FY;
        r_idx <= '0;
      end else begin
        if (w_advance && !w_last_idx)
          r_idx <= r_idx + 1'b1;
        if ((r_state == CHECK) && !w_eol && w_hit) begin
          r_x    <= attr_data[X_LSB +: 9];
          r_tile <= attr_data[TILE_LSB +: 9];
          r_pal  <= attr_data[PAL_LSB +: 5];
          r_row  <= w_row[3:0];
        end
        if ((r_state == FETCH0) && gfx_ack) r_w0 <= gfx_data;
        if ((r_state == FETCH1) && gfx_ack) r_w1 <= gfx_data;
      end
    end
  end

  front_pix_shifter u_shift (
    .clk     (clk),
    .i_rst   (VIDEO_RST),
    .i_load  ((r_state == LOAD) && CK0 && !HLD),
    .i_data  ({r_w1, r_w0}),
    .i_shift ((r_state == PIX) && CK0),
    .o_color (w_color),
    .o_last  (w_pix_last)
  );

  assign attr_addr = r_idx;
  assign gfx_req   = (r_state == FETCH0) || (r_state == FETCH1);
  assign gfx_addr  = {r_tile, r_row, (r_state == FETCH1)};
  assign LD        = (r_state == LOAD) && CK0;
  assign FL_Y      = r_x;
  assign FD        = ((r_state == PIX) && CK0) ? {r_pal, w_color} : 8'hFF;
  assign busy      = (r_state != IDLE) && (r_state != DONE);

endmodule

// File: tb/tb_front_line_writer.sv
// Scoreboard bench: line-scan reference model feeds expected LD/pixel events.
module tb_front_line_writer;

  localparam int NSPR = 8;
  localparam int IW   = $clog2(NSPR);

  logic          clk = 1'b0;
  logic          VIDEO_RST = 1'b1;
  logic          CK0 = 1'b0;
  logic          HLD = 1'b0;
  logic [8:0]    FY = '0;
  logic [IW-1:0] attr_addr;
  logic [31:0]   attr_data = '0;
  logic          gfx_req;
  logic [13:0]   gfx_addr;
  logic          gfx_ack = 1'b0;
  logic [23:0]   gfx_data = '0;
  logic [7:0]    FD;
  logic          LD;
  logic [8:0]    FL_Y;
  logic          busy;

  front_line_writer #(.NSPR(NSPR)) dut (
    .clk       (clk),
    .VIDEO_RST (VIDEO_RST),
    .CK0       (CK0),
    .HLD       (HLD),
    .FY        (FY),
    .attr_addr (attr_addr),
    .attr_data (attr_data),
    .gfx_req   (gfx_req),
    .gfx_addr  (gfx_addr),
    .gfx_ack   (gfx_ack),
    .gfx_data  (gfx_data),
    .FD        (FD),
    .LD        (LD),
    .FL_Y      (FL_Y),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_ld;
    logic [8:0] val;
  } ev_t;

  ev_t         exp_q[$];
  logic [13:0] gq[$];
  logic [31:0] mem [NSPR];
  int          tests = 0;
  int          fails = 0;
  int          pix_seen = 0;
  bit          gfx_seen = 1'b0;
  int          gfx_delay = 0;
  int          wait_cnt = 0;
  ev_t         mon_ev;

  function automatic logic [23:0] rom(input logic [13:0] a);
    return {a[9:0], ~a} ^ 24'h5A3C96 ^ {a, a[13:4]};
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] pal,
                                     input logic [8:0] tile,
                                     input logic [8:0] x,
                                     input logic [8:0] y);
    return {pal, tile, x, y};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected behaviour of one line: sprites in list order, each hit
  // producing one LD with its x and then 16 pixels from two ROM words.
  task automatic model_scan(input logic [8:0] fy);
    for (int i = 0; i < NSPR; i++) begin
      logic [8:0]  y, row, x, tile;
      logic [4:0]  pal;
      logic [13:0] a0;
      logic [23:0] w;
      logic [2:0]  c;
      y = mem[i][8:0];
      if (y == 9'h1FF) break;
      row = fy - y;
      if (row < 9'd16) begin
        x    = mem[i][17:9];
        tile = mem[i][26:18];
        pal  = mem[i][31:27];
        a0   = {tile, row[3:0], 1'b0};
        gq.push_back(a0);
        gq.push_back(a0 | 14'd1);
        exp_q.push_back('{1'b1, x});
        for (int n = 0; n < 16; n++) begin
          w = (n < 8) ? rom(a0) : rom(a0 | 14'd1);
          c = 3'((w >> (3 * (n % 8))) & 24'd7);
          exp_q.push_back('{1'b0, {1'b0, pal, c}});
        end
      end
    end
  endtask

  always @(posedge clk) attr_data <= mem[attr_addr];

  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      ph = (ph + 1) % 3;
      CK0 = (ph == 0);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      gfx_ack = 1'b0;
      if (!VIDEO_RST && gfx_req) begin
        if (wait_cnt >= gfx_delay) begin
          gfx_ack  = 1'b1;
          gfx_data = rom(gfx_addr);
          if (gq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL gfx_unexpected: got %0h expected none", gfx_addr);
          end else begin
            check("gfx_addr", 32'(gfx_addr), 32'(gq.pop_front()));
          end
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!VIDEO_RST) begin
      if (gfx_req) gfx_seen = 1'b1;
      if (gfx_req && FD !== 8'hFF) begin
        tests++;
        fails++;
        $display("FAIL req_with_pixel: got FD %0h expected ff", FD);
      end
      if (LD) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL ld_unexpected: got FL_Y %0d expected none", FL_Y);
        end else begin
          mon_ev = exp_q.pop_front();
          check("ld_kind", 32'(mon_ev.is_ld), 32'd1);
          check("FL_Y", 32'(FL_Y), 32'(mon_ev.val));
          check("FD_in_LD", 32'(FD), 32'hFF);
        end
      end else if (CK0 && FD !== 8'hFF) begin
        pix_seen++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pix_unexpected: got FD %0h expected none", FD);
        end else begin
          mon_ev = exp_q.pop_front();
          check("pix_kind", 32'(mon_ev.is_ld), 32'd0);
          check("FD", 32'(FD), 32'(mon_ev.val[7:0]));
        end
      end else if (!CK0 && (FD !== 8'hFF || LD !== 1'b0)) begin
        tests++;
        fails++;
        $display("FAIL idle_slot: got FD %0h LD %0b expected ff 0", FD, LD);
      end
    end
  end

  task automatic start_scan(input logic [8:0] fy);
    @(posedge clk);
    #1;
    exp_q.delete();
    gq.delete();
    pix_seen = 0;
    model_scan(fy);
    HLD = 1'b1;
    FY  = fy;
    @(posedge clk);
    #1;
    HLD = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      cyc++;
      if (cyc > 5000) begin
        tests++;
        fails++;
        $display("FAIL busy_timeout: got busy after %0d clk expected idle", cyc);
        break;
      end
    end
  endtask

  task automatic end_checks(input string name);
    repeat (4) @(negedge clk);
    check({name, "_exp_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_gfx_left"}, 32'(gq.size()), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic fill_eol();
    for (int i = 0; i < NSPR; i++) mem[i] = mk(5'd0, 9'd0, 9'd0, 9'h1FF);
  endtask

  initial begin
    int cyc;
    int k;
    logic [8:0] fy;
    #900000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int k;
    logic [8:0] fy;
    fill_eol();
    repeat (4) @(posedge clk);
    #1;
    VIDEO_RST = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("rst_FD", 32'(FD), 32'hFF);
      check("rst_LD", 32'(LD), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
    end
    check("rst_FL_Y", 32'(FL_Y), 32'd0);
    check("rst_req", 32'(gfx_req), 32'd0);
    check("rst_addr", 32'(attr_addr), 32'd0);

    fill_eol();
    mem[0] = mk(5'd3, 9'd5, 9'd100, 9'd10);
    gfx_delay = 1;
    start_scan(9'd20);
    check("hit_busy", 32'(busy), 32'd1);
    wait_done(cyc);
    end_checks("basic");

    fill_eol();
    mem[0] = mk(5'd0, 9'd0, 9'd0, 9'd30);
    gfx_seen = 1'b0;
    start_scan(9'd20);
    wait_done(cyc);
    check("miss_fall_le6", 32'(cyc <= 6), 32'd1);
    check("miss_no_gfx", 32'(gfx_seen), 32'd0);
    end_checks("miss");

    fill_eol();
    mem[0] = mk(5'd7, 9'd33, 9'd505, 9'd15);
    gfx_delay = 0;
    start_scan(9'd20);
    wait_done(cyc);
    end_checks("xwrap");

    fill_eol();
    mem[0] = mk(5'd12, 9'd200, 9'd40, 9'd500);
    gfx_delay = 7;
    start_scan(9'd2);
    wait_done(cyc);
    end_checks("ywrap");

    fill_eol();
    mem[0] = mk(5'd1, 9'd2, 9'd3, 9'd300);
    mem[1] = mk(5'd9, 9'd77, 9'd60, 9'd50);
    mem[2] = mk(5'd4, 9'd11, 9'd200, 9'd55);
    gfx_delay = 2;
    start_scan(9'd58);
    k = 0;
    while (pix_seen < 9 && k < 2000) begin
      @(posedge clk);
      k++;
    end
    check("abort_reach", 32'(pix_seen >= 9), 32'd1);
    #1;
    exp_q.delete();
    gq.delete();
    model_scan(9'd58);
    HLD = 1'b1;
    @(posedge clk);
    #1;
    HLD = 1'b0;
    @(negedge clk);
    check("abort_FD", 32'(FD), 32'hFF);
    check("abort_LD", 32'(LD), 32'd0);
    check("abort_idx", 32'(attr_addr), 32'd0);
    check("abort_busy", 32'(busy), 32'd1);
    wait_done(cyc);
    end_checks("abort");

    @(posedge clk);
    #1;
    VIDEO_RST = 1'b1;
    HLD = 1'b1;
    @(posedge clk);
    #1;
    VIDEO_RST = 1'b0;
    HLD = 1'b0;
    @(negedge clk);
    check("rst_prio_busy", 32'(busy), 32'd0);
    check("rst_prio_FD", 32'(FD), 32'hFF);

    for (int t = 0; t < 20; t++) begin
      fy = 9'($urandom_range(0, 511));
      for (int i = 0; i < NSPR; i++) begin
        if ($urandom_range(0, 7) == 0)
          mem[i] = mk(5'd0, 9'd0, 9'd0, 9'h1FF);
        else
          mem[i] = mk(5'($urandom_range(0, 30)), 9'($urandom),
                      9'($urandom), fy - 9'($urandom_range(0, 24)));
      end
      gfx_delay = $urandom_range(0, 3);
      start_scan(fy);
      wait_done(cyc);
      end_checks("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
